// File: rtl/ex_pkg.sv
// Shared encodings for the accumulator-pipeline execute stage.
package ex_pkg;

    // ALU operation encodings
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Operand-A forwarding select
    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_AC   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_REG2 = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, DATA_W cycles.
// done_o is asserted combinationally during the final step, with prod_o already
// holding the completed low DATA_W bits so the caller can register it that edge.
module ex_mul_seq #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] prod_o
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              busy_q, busy_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_next;
    logic              last_step;

    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (cnt_q == CntW'(DATA_W - 1));
    assign busy_o    = busy_q;
    assign done_o    = busy_q & last_step & ~abort_i;
    assign prod_o    = acc_next;

    // Next state: load on start, step while busy, drop out on abort or last step
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_step) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/ex_acc_stage.sv
// Execute stage of the accumulator pipeline: forwarding mux, ALU, AC-in/AC-out
// accumulators, zero flag, branch target and EX/MEM register, with a valid/ready
// handshake, flush, and a stalling multi-cycle multiply.
module ex_acc_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_W   = 2,
    parameter int unsigned CTRL_W = 6,
    parameter int unsigned MUL_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    input  logic [2:0]        op_i,
    input  logic              ld_ac_i,
    input  logic              imm_sel_i,
    input  logic              set_out_i,
    input  logic [1:0]        fwd_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] reg_val_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [RD_W-1:0]   rd_in_i,
    input  logic [CTRL_W-1:0] ctrl_in_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] ac_out_o,
    output logic              zero_o,
    output logic [DATA_W-1:0] jmp_tgt_o,
    output logic [DATA_W-1:0] rs_out_o,
    output logic [RD_W-1:0]   rd_out_o,
    output logic [CTRL_W-1:0] ctrl_out_o
);

    localparam int unsigned ShW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ex_state_e         state_q, state_d;
    logic              accept, is_mul;
    logic              mul_start, mul_abort, mul_done, mul_busy;
    logic [DATA_W-1:0] opa, alu_res, mul_prod;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ac_in_q, ac_in_d;
    logic [DATA_W-1:0] ac_out_q, ac_out_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] jmp_tgt_q, jmp_tgt_d;
    logic [DATA_W-1:0] rs_out_q, rs_out_d;
    logic [RD_W-1:0]   rd_out_q, rd_out_d;
    logic [CTRL_W-1:0] ctrl_out_q, ctrl_out_d;

    // Side-band of an in-flight multiply, presented together with the product
    logic              mul_set_q, mul_set_d;
    logic [RD_W-1:0]   mul_rd_q, mul_rd_d;
    logic [CTRL_W-1:0] mul_ctrl_q, mul_ctrl_d;
    logic [DATA_W-1:0] mul_jmp_q, mul_jmp_d;
    logic [DATA_W-1:0] mul_rs_q, mul_rs_d;

    assign in_ready_o = (state_q == S_IDLE);
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign is_mul     = (MUL_EN != 0) && (op_i == OP_MUL) && !ld_ac_i;
    assign mul_start  = accept & is_mul;
    assign mul_abort  = flush_i & (state_q == S_MUL);

    assign out_valid_o = out_valid_q;
    assign ac_out_o    = ac_out_q;
    assign zero_o      = zero_q;
    assign jmp_tgt_o   = jmp_tgt_q;
    assign rs_out_o    = rs_out_q;
    assign rd_out_o    = rd_out_q;
    assign ctrl_out_o  = ctrl_out_q;

    // Operand A forwarding; ac_out here is the previously committed result
    always_comb begin
        opa = reg_val_i;
        case (fwd_i)
            FWD_AC:  opa = ac_out_q;
            FWD_MEM: opa = mem_data_i;
            default: opa = reg_val_i;
        endcase
    end

    // Single-cycle ALU; MUL falls through to PASS (only reached when MUL_EN=0)
    always_comb begin
        alu_res = ac_in_q;
        unique case (op_i)
            OP_ADD:  alu_res = opa + ac_in_q;
            OP_SUB:  alu_res = opa - ac_in_q;
            OP_AND:  alu_res = opa & ac_in_q;
            OP_OR:   alu_res = opa | ac_in_q;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(ac_in_q))};
            OP_SHL:  alu_res = opa << ac_in_q[ShW-1:0];
            default: alu_res = ac_in_q;
        endcase
    end

    ex_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .abort_i (mul_abort),
        .a_i     (opa),
        .b_i     (ac_in_q),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // FSM next state: stall issue while a multiply runs; flush aborts it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (mul_start) state_d = S_MUL;
            S_MUL:  if (flush_i || mul_done || !mul_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // EX/MEM register and accumulator next-state
    always_comb begin
        out_valid_d = 1'b0;
        ctrl_out_d  = '0;
        ac_in_d     = ac_in_q;
        ac_out_d    = ac_out_q;
        zero_d      = zero_q;
        jmp_tgt_d   = jmp_tgt_q;
        rs_out_d    = rs_out_q;
        rd_out_d    = rd_out_q;
        mul_set_d   = mul_set_q;
        mul_rd_d    = mul_rd_q;
        mul_ctrl_d  = mul_ctrl_q;
        mul_jmp_d   = mul_jmp_q;
        mul_rs_d    = mul_rs_q;
        if (state_q == S_MUL) begin
            if (!flush_i && mul_done) begin
                out_valid_d = 1'b1;
                ctrl_out_d  = mul_ctrl_q;
                rd_out_d    = mul_rd_q;
                rs_out_d    = mul_rs_q;
                jmp_tgt_d   = mul_jmp_q;
                if (mul_set_q) begin
                    ac_out_d = mul_prod;
                    zero_d   = (mul_prod == '0);
                end
            end
        end else if (accept) begin
            if (is_mul) begin
                mul_set_d  = set_out_i;
                mul_rd_d   = rd_in_i;
                mul_ctrl_d = ctrl_in_i;
                mul_jmp_d  = pc_i + imm_i;
                mul_rs_d   = opa;
            end else begin
                out_valid_d = 1'b1;
                ctrl_out_d  = ctrl_in_i;
                rd_out_d    = rd_in_i;
                rs_out_d    = opa;
                jmp_tgt_d   = pc_i + imm_i;
                if (ld_ac_i) begin
                    ac_in_d = imm_sel_i ? imm_i : opa;
                end else if (set_out_i) begin
                    ac_out_d = alu_res;
                    zero_d   = (alu_res == '0);
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            ctrl_out_q  <= '0;
            ac_in_q     <= '0;
            ac_out_q    <= '0;
            zero_q      <= 1'b0;
            jmp_tgt_q   <= '0;
            rs_out_q    <= '0;
            rd_out_q    <= '0;
            mul_set_q   <= 1'b0;
            mul_rd_q    <= '0;
            mul_ctrl_q  <= '0;
            mul_jmp_q   <= '0;
            mul_rs_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_out_q  <= ctrl_out_d;
            ac_in_q     <= ac_in_d;
            ac_out_q    <= ac_out_d;
            zero_q      <= zero_d;
            jmp_tgt_q   <= jmp_tgt_d;
            rs_out_q    <= rs_out_d;
            rd_out_q    <= rd_out_d;
            mul_set_q   <= mul_set_d;
            mul_rd_q    <= mul_rd_d;
            mul_ctrl_q  <= mul_ctrl_d;
            mul_jmp_q   <= mul_jmp_d;
            mul_rs_q    <= mul_rs_d;
        end
    end

endmodule

// File: tb/tb_ex_acc_stage.sv
// Scoreboard bench for ex_acc_stage: expectations are pushed when an instruction
// is offered and popped when out_valid is seen.
module tb_ex_acc_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [2:0] op = 3'b000;
    logic       ld_ac = 1'b0;
    logic       imm_sel = 1'b0;
    logic       set_out = 1'b0;
    logic [1:0] fwd = 2'b00;
    logic [7:0] pc = 8'h00;
    logic [7:0] reg_val = 8'h00;
    logic [7:0] imm = 8'h00;
    logic [7:0] mem_data = 8'h00;
    logic [1:0] rd_in = 2'b00;
    logic [5:0] ctrl_in = 6'h00;
    logic       out_valid;
    logic [7:0] ac_out;
    logic       zero;
    logic [7:0] jmp_tgt;
    logic [7:0] rs_out;
    logic [1:0] rd_out;
    logic [5:0] ctrl_out;

    typedef struct packed {
        logic [7:0] ac;
        logic       z;
        logic [1:0] rd;
        logic [5:0] ctrl;
        logic [7:0] jmp;
        logic [7:0] rs;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] ac_in_m = 8'h00;
    logic [7:0] ac_out_m = 8'h00;
    logic       zero_m = 1'b0;

    ex_acc_stage #(
        .DATA_W (8),
        .RD_W   (2),
        .CTRL_W (6),
        .MUL_EN (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .flush_i    (flush),
        .op_i       (op),
        .ld_ac_i    (ld_ac),
        .imm_sel_i  (imm_sel),
        .set_out_i  (set_out),
        .fwd_i      (fwd),
        .pc_i       (pc),
        .reg_val_i  (reg_val),
        .imm_i      (imm),
        .mem_data_i (mem_data),
        .rd_in_i    (rd_in),
        .ctrl_in_i  (ctrl_in),
        .out_valid_o(out_valid),
        .ac_out_o   (ac_out),
        .zero_o     (zero),
        .jmp_tgt_o  (jmp_tgt),
        .rs_out_o   (rs_out),
        .rd_out_o   (rd_out),
        .ctrl_out_o (ctrl_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_model(input logic [2:0] o, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [15:0] p;
        case (o)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            3'b101: return a << b[2:0];
            3'b110: begin
                p = 16'(a) * 16'(b);
                return p[7:0];
            end
            default: return b;
        endcase
    endfunction

    // Offer one instruction; live=0 means no output is expected from it
    task automatic send(input logic [2:0] op_v, input logic ld_v, input logic isel_v,
                        input logic set_v, input logic [1:0] fwd_v, input logic [7:0] pc_v,
                        input logic [7:0] reg_v, input logic [7:0] imm_v,
                        input logic [7:0] mem_v, input logic [1:0] rd_v,
                        input logic [5:0] ctrl_v, input logic kill_v, input logic live_v);
        int         n;
        logic [7:0] a;
        logic [7:0] res;
        exp_t       e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        op = op_v; ld_ac = ld_v; imm_sel = isel_v; set_out = set_v; fwd = fwd_v;
        pc = pc_v; reg_val = reg_v; imm = imm_v; mem_data = mem_v;
        rd_in = rd_v; ctrl_in = ctrl_v; flush = kill_v; in_valid = 1'b1;
        a = (fwd_v == 2'b01) ? ac_out_m : (fwd_v == 2'b10) ? mem_v : reg_v;
        if (live_v) begin
            if (ld_v) begin
                ac_in_m = isel_v ? imm_v : a;
            end else if (set_v) begin
                res      = alu_model(op_v, a, ac_in_m);
                ac_out_m = res;
                zero_m   = (res == 8'h00);
            end
            e.ac = ac_out_m; e.z = zero_m; e.rd = rd_v; e.ctrl = ctrl_v;
            e.jmp = pc_v + imm_v; e.rs = a;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("ac_out", 32'(ac_out), 32'(mon_e.ac));
                    check_eq("zero", 32'(zero), 32'(mon_e.z));
                    check_eq("rd_out", 32'(rd_out), 32'(mon_e.rd));
                    check_eq("ctrl_out", 32'(ctrl_out), 32'(mon_e.ctrl));
                    check_eq("jmp_tgt", 32'(jmp_tgt), 32'(mon_e.jmp));
                    check_eq("rs_out", 32'(rs_out), 32'(mon_e.rs));
                end
            end else begin
                check_eq("ctrl_idle", 32'(ctrl_out), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] ac_hold;
        // Reset state
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ac_out", 32'(ac_out), 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        check_eq("rst_ctrl_out", 32'(ctrl_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ld_ac imm=5, ADD reg 3 -> 8
        send(3'b000, 1, 1, 0, 2'b00, 8'h10, 8'h00, 8'h05, 8'h00, 2'd1, 6'h21, 0, 1);
        send(3'b000, 0, 0, 1, 2'b00, 8'h11, 8'h03, 8'h02, 8'h00, 2'd2, 6'h12, 0, 1);
        @(negedge clk);
        check_eq("t2_ac_out", 32'(ac_out), 32'd8);
        check_eq("t2_zero", 32'(zero), 32'd0);

        // SUB 7-7 -> zero; SLT 0x80 < 1 -> 1
        send(3'b000, 1, 0, 0, 2'b00, 8'h20, 8'h07, 8'h00, 8'h00, 2'd0, 6'h01, 0, 1);
        send(3'b001, 0, 0, 1, 2'b00, 8'h21, 8'h07, 8'h00, 8'h00, 2'd3, 6'h3f, 0, 1);
        @(negedge clk);
        check_eq("t3_sub_ac", 32'(ac_out), 32'd0);
        check_eq("t3_sub_zero", 32'(zero), 32'd1);
        send(3'b000, 1, 1, 0, 2'b00, 8'h22, 8'h00, 8'h01, 8'h00, 2'd0, 6'h00, 0, 1);
        send(3'b100, 0, 0, 1, 2'b00, 8'h23, 8'h80, 8'hfe, 8'h00, 2'd1, 6'h05, 0, 1);
        @(negedge clk);
        check_eq("t3_slt_ac", 32'(ac_out), 32'd1);

        // MUL 13*11 = 0x8F with 8-cycle stall
        send(3'b000, 1, 1, 0, 2'b00, 8'h30, 8'h00, 8'h0b, 8'h00, 2'd0, 6'h00, 0, 1);
        send(3'b110, 0, 0, 1, 2'b00, 8'h31, 8'h0d, 8'h04, 8'h00, 2'd2, 6'h2a, 0, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
        end
        check_eq("t4_stall_cycles", 32'(cnt), 32'd8);
        check_eq("t4_out_valid", 32'(out_valid), 32'd1);
        check_eq("t4_ac_out", 32'(ac_out), 32'h8f);

        // Back-to-back ADDs, second forwards ac_out
        send(3'b000, 1, 1, 0, 2'b00, 8'h40, 8'h00, 8'h02, 8'h00, 2'd0, 6'h00, 0, 1);
        send(3'b000, 0, 0, 1, 2'b00, 8'h41, 8'h01, 8'h00, 8'h00, 2'd1, 6'h11, 0, 1);
        send(3'b000, 0, 0, 1, 2'b01, 8'h42, 8'h99, 8'h00, 8'h00, 2'd2, 6'h22, 0, 1);
        @(negedge clk);
        check_eq("t5_fwd_ac", 32'(ac_out), 32'd5);

        // Random mix
        for (int i = 0; i < 30; i++) begin
            send(3'($urandom_range(7)), 1'($urandom_range(3) == 0), 1'($urandom),
                 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 2'($urandom), 6'($urandom), 0, 1);
        end

        // Flush during MUL cycle 4
        send(3'b000, 1, 1, 0, 2'b00, 8'h50, 8'h00, 8'h03, 8'h00, 2'd0, 6'h00, 0, 1);
        send(3'b110, 0, 0, 1, 2'b00, 8'h51, 8'h09, 8'h00, 8'h00, 2'd3, 6'h33, 0, 0);
        ac_hold = ac_out_m;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_eq("t6_in_ready", 32'(in_ready), 32'd1);
        check_eq("t6_out_valid", 32'(out_valid), 32'd0);
        check_eq("t6_ac_out", 32'(ac_out), 32'(ac_hold));
        // Flush with an offered ADD drops it
        send(3'b000, 0, 0, 1, 2'b00, 8'h52, 8'h44, 8'h00, 8'h00, 2'd1, 6'h15, 1, 0);
        repeat (12) @(negedge clk);
        check_eq("t6_drop_ac_out", 32'(ac_out), 32'(ac_hold));

        // Reset mid-MUL, asynchronous
        send(3'b110, 0, 0, 1, 2'b00, 8'h60, 8'h07, 8'h00, 8'h00, 2'd1, 6'h0f, 0, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t1_in_ready", 32'(in_ready), 32'd1);
        check_eq("t1_out_valid", 32'(out_valid), 32'd0);
        check_eq("t1_ac_out", 32'(ac_out), 32'd0);
        check_eq("t1_rs_out", 32'(rs_out), 32'd0);
        check_eq("t1_jmp_tgt", 32'(jmp_tgt), 32'd0);
        exp_q.delete();
        ac_in_m = 8'h00; ac_out_m = 8'h00; zero_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(3'b000, 0, 0, 1, 2'b00, 8'h70, 8'h04, 8'h00, 8'h00, 2'd2, 6'h07, 0, 1);
        @(negedge clk);
        check_eq("t1_post_ac", 32'(ac_out), 32'd4);

        repeat (20) @(negedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
